// File: rtl/kart_pkg.sv
// Shared definitions for the kart drive path: motion command codes,
// H-bridge IN pair encodings, wheel direction and wheel FSM state codes.
package kart_pkg;

  // Motion commands from the line-tracking decision stage
  localparam logic [2:0] CMD_STOP      = 3'b000;
  localparam logic [2:0] CMD_FORWARD   = 3'b001;
  localparam logic [2:0] CMD_LEFT      = 3'b010;
  localparam logic [2:0] CMD_RIGHT     = 3'b011;
  localparam logic [2:0] CMD_RSVD      = 3'b100;
  localparam logic [2:0] CMD_BACKWARD  = 3'b101;
  localparam logic [2:0] CMD_BACKLEFT  = 3'b110;
  localparam logic [2:0] CMD_BACKRIGHT = 3'b111;

  // H-bridge IN1/IN2 encodings
  localparam logic [1:0] BR_COAST = 2'b00;
  localparam logic [1:0] BR_BACK  = 2'b01;
  localparam logic [1:0] BR_FWD   = 2'b10;
  localparam logic [1:0] BR_BRAKE = 2'b11;

  // Wheel rotation sign
  localparam logic DIR_FWD  = 1'b0;
  localparam logic DIR_BACK = 1'b1;

  // Wheel FSM state codes
  typedef logic [1:0] wheel_state_t;
  localparam wheel_state_t WS_COAST = 2'd0;
  localparam wheel_state_t WS_RUN   = 2'd1;
  localparam wheel_state_t WS_BRAKE = 2'd2;

  // Bridge IN pair for a wheel that is driving in direction dir
  function automatic logic [1:0] bridge_code(input logic dir);
    return (dir == DIR_BACK) ? BR_BACK : BR_FWD;
  endfunction

endpackage

// File: rtl/wheel_channel.sv
// One wheel of the drive: direction FSM, duty slew limiter, reversal
// dead-time counter and PWM compare against the shared period counter.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   WS_COAST | bridge 00, duty 0; leaves as soon as a non-zero duty is asked
//   WS_RUN   | bridge drives dir; duty slews toward target at period wrap
//   WS_BRAKE | bridge 11, pwm 0 for DEADTIME cycles after a reversal request
module wheel_channel
  import kart_pkg::*;
#(
  parameter int PWM_BITS  = 4,
  parameter int RAMP_STEP = 2,
  parameter int DEADTIME  = 16
) (
  input  logic                ms_clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                wrap,
  input  logic                tgt_dir,
  input  logic [PWM_BITS-1:0] tgt_duty,
  output logic [1:0]          bridge_in,
  output logic                pwm,
  output logic                active
);

  localparam int DW     = PWM_BITS + 1;
  localparam int DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  // Counter runs DEADTIME-1 down to 0, giving exactly DEADTIME brake cycles
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEADTIME - 1);
  localparam logic [DW-1:0]     STEP      = DW'(RAMP_STEP);

  wheel_state_t        st;
  logic                dir;
  logic [PWM_BITS-1:0] duty;
  logic [DEAD_W-1:0]   dead_cnt;

  logic [DW-1:0]       duty_x;
  logic [DW-1:0]       tgt_x;
  logic [PWM_BITS-1:0] ramp_duty;
  logic                reverse;

  // Next duty one slew step toward target, computed a bit wider so the step never wraps
  always_comb begin
    duty_x    = {1'b0, duty};
    tgt_x     = {1'b0, tgt_duty};
    ramp_duty = duty;
    if (tgt_x > duty_x) begin
      if ((tgt_x - duty_x) > STEP) ramp_duty = PWM_BITS'(duty_x + STEP);
      else                         ramp_duty = tgt_duty;
    end else if (tgt_x < duty_x) begin
      if ((duty_x - tgt_x) > STEP) ramp_duty = PWM_BITS'(duty_x - STEP);
      else                         ramp_duty = tgt_duty;
    end
  end

  // A zero target carries no sign, so STOP never triggers a reversal
  assign reverse = (tgt_duty != '0) && (tgt_dir != dir);

  // Wheel FSM with duty slew and reversal dead-time
  always_ff @(posedge ms_clk or posedge reset) begin
    if (reset) begin
      st       <= WS_COAST;
      dir      <= DIR_FWD;
      duty     <= '0;
      dead_cnt <= '0;
    end else begin
      case (st)
        WS_COAST: begin
          if (tgt_duty != '0) begin
            st   <= WS_RUN;
            dir  <= tgt_dir;
            duty <= '0;
          end
        end
        WS_RUN: begin
          if (reverse) begin
            st       <= WS_BRAKE;
            duty     <= '0;
            dead_cnt <= DEAD_LOAD;
          end else if (wrap) begin
            duty <= ramp_duty;
            if ((tgt_duty == '0) && (ramp_duty == '0)) st <= WS_COAST;
          end
        end
        WS_BRAKE: begin
          if (dead_cnt == '0) begin
            duty <= '0;
            if (tgt_duty == '0) begin
              st <= WS_COAST;
            end else begin
              st  <= WS_RUN;
              dir <= tgt_dir;
            end
          end else begin
            dead_cnt <= dead_cnt - DEAD_W'(1);
          end
        end
        default: begin
          st   <= WS_COAST;
          duty <= '0;
        end
      endcase
    end
  end

  // Bridge IN pair follows the FSM state directly
  always_comb begin
    bridge_in = BR_COAST;
    case (st)
      WS_RUN:   bridge_in = bridge_code(dir);
      WS_BRAKE: bridge_in = BR_BRAKE;
      default:  bridge_in = BR_COAST;
    endcase
  end

  assign pwm    = (st == WS_RUN) && (pwm_cnt < duty);
  assign active = (duty != '0) || (st == WS_BRAKE);

endmodule

// File: rtl/motor_drive_ctrl.sv
// Two-wheel H-bridge driver: decodes the motion command into per-wheel
// sign/duty targets, owns the shared PWM period counter and the moving flag.
// Build option PIVOT_TURN_EN: LEFT/RIGHT spin the inner wheel backwards
// instead of running it slower in the same direction.
module motor_drive_ctrl
  import kart_pkg::*;
#(
  parameter int PWM_BITS   = 4,
  parameter int DUTY_FWD   = 12,
  parameter int DUTY_BACK  = 10,
  parameter int DUTY_OUTER = 12,
  parameter int DUTY_INNER = 5,
  parameter int RAMP_STEP  = 2,
  parameter int DEADTIME   = 16
) (
  input  logic       ms_clk,
  input  logic       reset,
  input  logic [2:0] state,
  output logic [1:0] left_in,
  output logic [1:0] right_in,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic       moving
);

  localparam logic [PWM_BITS-1:0] D_FWD   = PWM_BITS'(DUTY_FWD);
  localparam logic [PWM_BITS-1:0] D_BACK  = PWM_BITS'(DUTY_BACK);
  localparam logic [PWM_BITS-1:0] D_OUTER = PWM_BITS'(DUTY_OUTER);
  localparam logic [PWM_BITS-1:0] D_INNER = PWM_BITS'(DUTY_INNER);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                wrap;
  logic                l_dir, r_dir;
  logic [PWM_BITS-1:0] l_duty, r_duty;
  logic                l_active, r_active;

  // Free-running PWM period counter shared by both wheels
  always_ff @(posedge ms_clk or posedge reset) begin
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  assign wrap = &pwm_cnt;

  // Motion command to per-wheel sign and target duty
  always_comb begin
    l_dir  = DIR_FWD;
    r_dir  = DIR_FWD;
    l_duty = '0;
    r_duty = '0;
    case (state)
      CMD_FORWARD: begin
        l_duty = D_FWD;
        r_duty = D_FWD;
      end
      CMD_BACKWARD: begin
        l_dir  = DIR_BACK;
        r_dir  = DIR_BACK;
        l_duty = D_BACK;
        r_duty = D_BACK;
      end
      CMD_LEFT: begin
`ifdef PIVOT_TURN_EN
        l_dir  = DIR_BACK;
`endif
        l_duty = D_INNER;
        r_duty = D_OUTER;
      end
      CMD_RIGHT: begin
`ifdef PIVOT_TURN_EN
        r_dir  = DIR_BACK;
`endif
        l_duty = D_OUTER;
        r_duty = D_INNER;
      end
      CMD_BACKLEFT: begin
        l_dir  = DIR_BACK;
        r_dir  = DIR_BACK;
        l_duty = D_INNER;
        r_duty = D_OUTER;
      end
      CMD_BACKRIGHT: begin
        l_dir  = DIR_BACK;
        r_dir  = DIR_BACK;
        l_duty = D_OUTER;
        r_duty = D_INNER;
      end
      CMD_STOP, CMD_RSVD: begin
        l_duty = '0;
        r_duty = '0;
      end
    endcase
  end

  wheel_channel #(
    .PWM_BITS (PWM_BITS),
    .RAMP_STEP(RAMP_STEP),
    .DEADTIME (DEADTIME)
  ) u_left (
    .ms_clk   (ms_clk),
    .reset    (reset),
    .pwm_cnt  (pwm_cnt),
    .wrap     (wrap),
    .tgt_dir  (l_dir),
    .tgt_duty (l_duty),
    .bridge_in(left_in),
    .pwm      (left_pwm),
    .active   (l_active)
  );

  wheel_channel #(
    .PWM_BITS (PWM_BITS),
    .RAMP_STEP(RAMP_STEP),
    .DEADTIME (DEADTIME)
  ) u_right (
    .ms_clk   (ms_clk),
    .reset    (reset),
    .pwm_cnt  (pwm_cnt),
    .wrap     (wrap),
    .tgt_dir  (r_dir),
    .tgt_duty (r_duty),
    .bridge_in(right_in),
    .pwm      (right_pwm),
    .active   (r_active)
  );

  assign moving = l_active | r_active;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Scoreboard bench for motor_drive_ctrl. Stimulus pushes expected output
// values tagged with the tick they must appear on; the monitor pops and
// compares them. Wheel duty is observed as pwm-high count per PWM period.
module tb_motor_drive_ctrl;

  logic       ms_clk = 1'b0;
  logic       reset  = 1'b1;
  logic [2:0] state  = 3'b001;
  logic [1:0] left_in, right_in;
  logic       left_pwm, right_pwm, moving;

  localparam int K_LIN = 0, K_RIN = 1, K_LPWM = 2, K_RPWM = 3, K_MOV = 4, K_LDU = 5, K_RDU = 6;
  localparam int B  = 3;      // tick of first reset release
  localparam int B2 = B + 640; // tick of second reset release

  typedef struct {
    int    due;
    int    kind;
    int    expv;
    string nm;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tick  = 0;
  logic [3:0] ph;
  int   acc_l = 0, acc_r = 0;

  motor_drive_ctrl dut (
    .ms_clk   (ms_clk),
    .reset    (reset),
    .state    (state),
    .left_in  (left_in),
    .right_in (right_in),
    .left_pwm (left_pwm),
    .right_pwm(right_pwm),
    .moving   (moving)
  );

  always #5 ms_clk = ~ms_clk;

  always @(posedge ms_clk) tick <= tick + 1;

  // Bench-side period phase, used only to delimit duty measurement windows
  always @(posedge ms_clk or posedge reset) begin
    if (reset) ph <= 4'd0;
    else       ph <= ph + 4'd1;
  end

  function automatic void ex(input int due, input int kind, input int expv, input string nm);
    exp_t e;
    int   i;
    e.due = due; e.kind = kind; e.expv = expv; e.nm = nm;
    i = sbq.size();
    while (i > 0 && sbq[i-1].due > due) i--;
    sbq.insert(i, e);
  endfunction

  function automatic int actual(input int kind);
    case (kind)
      K_LIN:   return int'(left_in);
      K_RIN:   return int'(right_in);
      K_LPWM:  return int'(left_pwm);
      K_RPWM:  return int'(right_pwm);
      K_MOV:   return int'(moving);
      K_LDU:   return acc_l;
      default: return acc_r;
    endcase
  endfunction

  function automatic int ramp_to12(input int p);
    return (2 * p > 12) ? 12 : 2 * p;
  endfunction

  task automatic wait_tick(input int t);
    while (tick < t) @(negedge ms_clk);
  endtask

  // Monitor: accumulate pwm per period, then check everything due now
  initial begin
    exp_t e;
    int   a;
    forever begin
      @(negedge ms_clk);
      #2;
      if (ph == 4'd0) begin
        acc_l = 0;
        acc_r = 0;
      end
      acc_l += int'(left_pwm);
      acc_r += int'(right_pwm);
      while (sbq.size() > 0 && sbq[0].due <= tick) begin
        e = sbq.pop_front();
        a = actual(e.kind);
        n_cmp++;
        if (e.due != tick || a != e.expv) begin
          n_bad++;
          $display("FAIL %s: got %0d at tick %0d, expected %0d at tick %0d", e.nm, a, tick, e.expv, e.due);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, %0d checks pending", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   k;
    // reset held with FORWARD applied, then release
    ex(2, K_LIN, 0, "rst_left_in");
    ex(2, K_RIN, 0, "rst_right_in");
    ex(2, K_LPWM, 0, "rst_left_pwm");
    ex(2, K_RPWM, 0, "rst_right_pwm");
    ex(2, K_MOV, 0, "rst_moving");
    ex(B + 1, K_LIN, 2, "rel_left_in_fwd");
    ex(B + 1, K_RIN, 2, "rel_right_in_fwd");
    ex(B + 1, K_MOV, 0, "rel_moving_duty0");
    ex(B + 16, K_MOV, 1, "ramp_moving_up");
    for (int p = 0; p < 8; p++) begin
      ex(B + 16*p + 15, K_LDU, ramp_to12(p), $sformatf("fwd_ramp_l_p%0d", p));
      ex(B + 16*p + 15, K_RDU, ramp_to12(p), $sformatf("fwd_ramp_r_p%0d", p));
    end
    wait_tick(2);
    #1;
    n_cmp++;
    if (left_in !== 2'b00) begin
      n_bad++;
      $display("FAIL held_rst_left_in: got %0b", left_in);
    end
    n_cmp++;
    if (right_in !== 2'b00) begin
      n_bad++;
      $display("FAIL held_rst_right_in: got %0b", right_in);
    end
    n_cmp++;
    if (left_pwm !== 1'b0) begin
      n_bad++;
      $display("FAIL held_rst_left_pwm: got %0b", left_pwm);
    end
    n_cmp++;
    if (right_pwm !== 1'b0) begin
      n_bad++;
      $display("FAIL held_rst_right_pwm: got %0b", right_pwm);
    end
    n_cmp++;
    if (moving !== 1'b0) begin
      n_bad++;
      $display("FAIL held_rst_moving: got %0b", moving);
    end
    wait_tick(B);
    reset = 1'b0;

    // FORWARD -> LEFT (differential), then back to FORWARD
    wait_tick(B + 130);
    state = 3'b010;
    ex(B + 131, K_LIN, 2, "left_turn_lin");
    ex(B + 131, K_RIN, 2, "left_turn_rin");
    ex(B + 8*16 + 15,  K_LDU, 12, "turn_l_p8");
    ex(B + 9*16 + 15,  K_LDU, 10, "turn_l_p9");
    ex(B + 10*16 + 15, K_LDU, 8,  "turn_l_p10");
    ex(B + 11*16 + 15, K_LDU, 6,  "turn_l_p11");
    ex(B + 12*16 + 15, K_LDU, 5,  "turn_l_p12");
    ex(B + 13*16 + 15, K_LDU, 5,  "turn_l_p13");
    ex(B + 9*16 + 15,  K_RDU, 12, "turn_r_p9");
    ex(B + 12*16 + 15, K_RDU, 12, "turn_r_p12");
    wait_tick(B + 210);
    state = 3'b001;
    ex(B + 14*16 + 15, K_LDU, 7,  "refwd_l_p14");
    ex(B + 15*16 + 15, K_LDU, 9,  "refwd_l_p15");
    ex(B + 16*16 + 15, K_LDU, 11, "refwd_l_p16");
    ex(B + 17*16 + 15, K_LDU, 12, "refwd_l_p17");

    // reserved code 3'b100 ramps down to COAST
    wait_tick(B + 274);
    state = 3'b100;
    for (int p = 18; p < 24; p++)
      ex(B + 16*p + 15, K_LDU, 10 - 2*(p - 18), $sformatf("stop_l_p%0d", p));
    ex(B + 18*16 + 15, K_RDU, 10, "stop_r_p18");
    ex(B + 22*16 + 15, K_RDU, 2,  "stop_r_p22");
    ex(B + 367, K_MOV, 1, "stop_moving_before");
    ex(B + 367, K_LIN, 2, "stop_lin_before");
    ex(B + 368, K_MOV, 0, "stop_moving_drop");
    ex(B + 368, K_LIN, 0, "stop_lin_coast");
    ex(B + 368, K_RIN, 0, "stop_rin_coast");

    // FORWARD from COAST, then reversal to BACKWARD through BRAKE
    wait_tick(B + 370);
    state = 3'b001;
    ex(B + 371, K_LIN, 2, "coast_to_run_lin");
    for (int p = 24; p < 30; p++)
      ex(B + 16*p + 15, K_LDU, ramp_to12(p - 23), $sformatf("fwd2_l_p%0d", p));
    ex(B + 29*16 + 15, K_RDU, 12, "fwd2_r_p29");
    wait_tick(B + 482);
    state = 3'b101;
    ex(B + 483, K_LIN, 3, "brake_start_lin");
    ex(B + 483, K_RIN, 3, "brake_start_rin");
    ex(B + 483, K_MOV, 1, "brake_moving");
    ex(B + 498, K_LIN, 3, "brake_last_lin");
    ex(B + 498, K_LPWM, 0, "brake_last_lpwm");
    ex(B + 499, K_LIN, 1, "brake_exit_lin");
    ex(B + 499, K_RIN, 1, "brake_exit_rin");
    ex(B + 499, K_MOV, 0, "brake_exit_moving");
    ex(B + 30*16 + 15, K_LDU, 3, "rev_l_p30");
    ex(B + 30*16 + 15, K_RDU, 3, "rev_r_p30");
    ex(B + 31*16 + 15, K_LDU, 0, "rev_l_p31");
    ex(B + 31*16 + 15, K_RDU, 0, "rev_r_p31");
    for (int p = 32; p < 38; p++)
      ex(B + 16*p + 15, K_LDU, (2*(p - 31) > 10) ? 10 : 2*(p - 31), $sformatf("back_l_p%0d", p));
    ex(B + 37*16 + 15, K_RDU, 10, "back_r_p37");

    // reset asserted mid-BRAKE
    wait_tick(B + 610);
    state = 3'b001;
    ex(B + 611, K_LIN, 3, "brake2_lin");
    ex(B + 614, K_MOV, 1, "brake2_moving");
    wait_tick(B + 615);
    reset = 1'b1;
    ex(B + 615, K_LIN, 0, "midbrake_rst_lin");
    ex(B + 615, K_RIN, 0, "midbrake_rst_rin");
    ex(B + 615, K_LPWM, 0, "midbrake_rst_lpwm");
    ex(B + 615, K_RPWM, 0, "midbrake_rst_rpwm");
    ex(B + 615, K_MOV, 0, "midbrake_rst_moving");
    #1;
    n_cmp++;
    if (left_in !== 2'b00) begin
      n_bad++;
      $display("FAIL async_rst_left_in: got %0b", left_in);
    end
    n_cmp++;
    if (right_in !== 2'b00) begin
      n_bad++;
      $display("FAIL async_rst_right_in: got %0b", right_in);
    end
    n_cmp++;
    if (left_pwm !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst_left_pwm: got %0b", left_pwm);
    end
    n_cmp++;
    if (right_pwm !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst_right_pwm: got %0b", right_pwm);
    end
    n_cmp++;
    if (moving !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst_moving: got %0b", moving);
    end
    wait_tick(B2);
    reset = 1'b0;

    // FORWARD ramp again, then LEFT in the selected turn style
    ex(B2 + 1, K_LIN, 2, "rel2_lin");
    for (int p = 1; p < 7; p++)
      ex(B2 + 16*p + 15, K_LDU, ramp_to12(p), $sformatf("fwd3_l_p%0d", p));
    wait_tick(B2 + 114);
    state = 3'b010;
    ex(B2 + 131, K_RIN, 2, "turn2_rin");
    ex(B2 + 8*16 + 15, K_RDU, 12, "turn2_r_p8");
`ifdef PIVOT_TURN_EN
    ex(B2 + 115, K_LIN, 3, "pivot_brake_lin");
    ex(B2 + 130, K_LIN, 3, "pivot_brake_last_lin");
    ex(B2 + 131, K_LIN, 1, "pivot_back_lin");
    ex(B2 + 7*16 + 15, K_LDU, 3, "pivot_l_p7");
    ex(B2 + 8*16 + 15, K_LDU, 0, "pivot_l_p8");
    ex(B2 + 9*16 + 15, K_LDU, 2, "pivot_l_p9");
`else
    ex(B2 + 115, K_LIN, 2, "diff_turn_lin");
    ex(B2 + 7*16 + 15, K_LDU, 12, "diff_l_p7");
    ex(B2 + 8*16 + 15, K_LDU, 10, "diff_l_p8");
    ex(B2 + 9*16 + 15, K_LDU, 8,  "diff_l_p9");
`endif

    wait_tick(B2 + 160);
    k = 0;
    while (sbq.size() > 0 && k < 100) begin
      @(negedge ms_clk);
      k++;
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: never checked, expected %0d at tick %0d", e.nm, e.expv, e.due);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
